// File: rtl/branch_commit_unit.sv
// Branch commit tracker: holds per-ROB-tag prediction/outcome, drives predictor updates and
// mispredict flushes at in-order commit. Define BRANCH_STAT_EN to add commit/mispredict counters.
module branch_commit_unit #(
  parameter int unsigned ROB_TAG_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     alloc_valid_in,
  input  logic [ROB_TAG_WIDTH-1:0] alloc_tag_in,
  input  logic [ADDR_WIDTH-1:0]    alloc_pc_in,
  input  logic                     alloc_pred_taken_in,
  input  logic [ADDR_WIDTH-1:0]    alloc_pred_target_in,
  input  logic                     resolve_valid_in,
  input  logic [ROB_TAG_WIDTH-1:0] resolve_tag_in,
  input  logic                     resolve_taken_in,
  input  logic [ADDR_WIDTH-1:0]    resolve_target_in,
  input  logic                     commit_valid_in,
  input  logic [ROB_TAG_WIDTH-1:0] commit_tag_in,
  output logic                     commit_ready_out,
  output logic                     enable_to_predictor,
  output logic [ADDR_WIDTH-1:0]    inst_addr_to_predictor,
  output logic                     jump_result_to_predictor,
  output logic                     flush_out,
`ifdef BRANCH_STAT_EN
  output logic [31:0]              stat_branches_out,
  output logic [31:0]              stat_mispredicts_out,
`endif
  output logic [ADDR_WIDTH-1:0]    redirect_pc_out
);

  localparam int unsigned Entries = 1 << ROB_TAG_WIDTH;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [Entries-1:0]     valid_q, valid_d;
  logic [Entries-1:0]     resolved_q, resolved_d;
  logic [ADDR_WIDTH-1:0]  pc_q          [Entries];
  logic                   pred_taken_q  [Entries];
  logic [ADDR_WIDTH-1:0]  pred_target_q [Entries];
  logic                   taken_q       [Entries];
  logic [ADDR_WIDTH-1:0]  target_q      [Entries];

  logic                   enable_q, enable_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   result_q, result_d;
  logic                   flush_q, flush_d;
  logic [ADDR_WIDTH-1:0]  redirect_q, redirect_d;

  logic                   commit_acc, mispredict, alloc_write, res_write;
  logic [ADDR_WIDTH-1:0]  redirect_calc;

  always_comb begin
    commit_ready_out = (state_q == StIdle) && valid_q[commit_tag_in] && resolved_q[commit_tag_in];
    commit_acc       = commit_valid_in && commit_ready_out;
    mispredict       = (pred_taken_q[commit_tag_in] != taken_q[commit_tag_in]) ||
                       (taken_q[commit_tag_in] &&
                        (target_q[commit_tag_in] != pred_target_q[commit_tag_in]));
    redirect_calc    = taken_q[commit_tag_in] ? target_q[commit_tag_in]
                                              : pc_q[commit_tag_in] + ADDR_WIDTH'(4);
    alloc_write      = (state_q == StIdle) && alloc_valid_in;
    // Alloc to the same tag in the same cycle wins over resolve.
    res_write        = (state_q == StIdle) && resolve_valid_in && valid_q[resolve_tag_in] &&
                       !(alloc_valid_in && (alloc_tag_in == resolve_tag_in));
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    resolved_d = resolved_q;
    enable_d   = 1'b0;
    addr_d     = addr_q;
    result_d   = result_q;
    flush_d    = 1'b0;
    redirect_d = redirect_q;
    if (state_q == StFlush) begin
      valid_d    = '0;
      resolved_d = '0;
      state_d    = StIdle;
    end else begin
      if (res_write) resolved_d[resolve_tag_in] = 1'b1;
      if (commit_acc) begin
        valid_d[commit_tag_in] = 1'b0;
        enable_d = 1'b1;
        addr_d   = pc_q[commit_tag_in];
        result_d = taken_q[commit_tag_in];
        if (mispredict) begin
          flush_d    = 1'b1;
          redirect_d = redirect_calc;
          state_d    = StFlush;
        end
      end
      // Applied after commit so a same-tag commit retires the old contents first.
      if (alloc_write) begin
        valid_d[alloc_tag_in]    = 1'b1;
        resolved_d[alloc_tag_in] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      resolved_q <= '0;
      enable_q   <= 1'b0;
      addr_q     <= '0;
      result_q   <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      enable_q   <= enable_d;
      addr_q     <= addr_d;
      result_q   <= result_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by valid_q/resolved_q.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (alloc_write) begin
        pc_q[alloc_tag_in]          <= alloc_pc_in;
        pred_taken_q[alloc_tag_in]  <= alloc_pred_taken_in;
        pred_target_q[alloc_tag_in] <= alloc_pred_target_in;
      end
      if (res_write) begin
        taken_q[resolve_tag_in]  <= resolve_taken_in;
        target_q[resolve_tag_in] <= resolve_target_in;
      end
    end
  end

  assign enable_to_predictor      = enable_q;
  assign inst_addr_to_predictor   = addr_q;
  assign jump_result_to_predictor = result_q;
  assign flush_out                = flush_q;
  assign redirect_pc_out          = redirect_q;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q + {31'd0, commit_acc};
    stat_mp_d = stat_mp_q + {31'd0, commit_acc && mispredict};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (rdy_in) begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_out    = stat_br_q;
  assign stat_mispredicts_out = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_commit_unit.sv
// Directed bench for branch_commit_unit; checks are immediate assertions at fixed points.
module tb_branch_commit_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        alloc_valid_in, alloc_pred_taken_in;
  logic [3:0]  alloc_tag_in;
  logic [31:0] alloc_pc_in, alloc_pred_target_in;
  logic        resolve_valid_in, resolve_taken_in;
  logic [3:0]  resolve_tag_in;
  logic [31:0] resolve_target_in;
  logic        commit_valid_in;
  logic [3:0]  commit_tag_in;
  logic        commit_ready_out, enable_to_predictor, jump_result_to_predictor, flush_out;
  logic [31:0] inst_addr_to_predictor, redirect_pc_out;
`ifdef BRANCH_STAT_EN
  logic [31:0] stat_branches_out, stat_mispredicts_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  branch_commit_unit #(.ROB_TAG_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .rdy_in                   (rdy_in),
    .alloc_valid_in           (alloc_valid_in),
    .alloc_tag_in             (alloc_tag_in),
    .alloc_pc_in              (alloc_pc_in),
    .alloc_pred_taken_in      (alloc_pred_taken_in),
    .alloc_pred_target_in     (alloc_pred_target_in),
    .resolve_valid_in         (resolve_valid_in),
    .resolve_tag_in           (resolve_tag_in),
    .resolve_taken_in         (resolve_taken_in),
    .resolve_target_in        (resolve_target_in),
    .commit_valid_in          (commit_valid_in),
    .commit_tag_in            (commit_tag_in),
    .commit_ready_out         (commit_ready_out),
    .enable_to_predictor      (enable_to_predictor),
    .inst_addr_to_predictor   (inst_addr_to_predictor),
    .jump_result_to_predictor (jump_result_to_predictor),
    .flush_out                (flush_out),
`ifdef BRANCH_STAT_EN
    .stat_branches_out        (stat_branches_out),
    .stat_mispredicts_out     (stat_mispredicts_out),
`endif
    .redirect_pc_out          (redirect_pc_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_alloc(input logic [3:0] t, input logic [31:0] pc, input logic pt,
                          input logic [31:0] tgt);
    alloc_valid_in = 1'b1; alloc_tag_in = t; alloc_pc_in = pc;
    alloc_pred_taken_in = pt; alloc_pred_target_in = tgt;
    step();
    alloc_valid_in = 1'b0;
  endtask

  task automatic do_resolve(input logic [3:0] t, input logic tk, input logic [31:0] tgt);
    resolve_valid_in = 1'b1; resolve_tag_in = t; resolve_taken_in = tk;
    resolve_target_in = tgt;
    step();
    resolve_valid_in = 1'b0;
  endtask

  // Drive a commit for one edge; outputs are then those of the cycle after acceptance.
  task automatic do_commit(input logic [3:0] t);
    commit_valid_in = 1'b1; commit_tag_in = t;
    step();
    commit_valid_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    alloc_valid_in = 0; alloc_tag_in = 0; alloc_pc_in = 0;
    alloc_pred_taken_in = 0; alloc_pred_target_in = 0;
    resolve_valid_in = 0; resolve_tag_in = 0; resolve_taken_in = 0; resolve_target_in = 0;
    commit_valid_in = 0; commit_tag_in = 0;
    step(); step();
    rst_in = 1'b0;
    chk("rst_enable", enable_to_predictor, 0);
    chk("rst_addr", inst_addr_to_predictor, 0);
    chk("rst_result", jump_result_to_predictor, 0);
    chk("rst_flush", flush_out, 0);
    chk("rst_redirect", redirect_pc_out, 0);
    chk("rst_ready", commit_ready_out, 0);

    // Correctly predicted not-taken branch.
    do_alloc(4'd3, 32'h100, 1'b0, 32'h140);
    do_resolve(4'd3, 1'b0, 32'h140);
    commit_tag_in = 4'd3; #1;
    chk("t1_ready", commit_ready_out, 1);
    do_commit(4'd3);
    chk("t1_enable", enable_to_predictor, 1);
    chk("t1_addr", inst_addr_to_predictor, 32'h100);
    chk("t1_result", jump_result_to_predictor, 0);
    chk("t1_flush", flush_out, 0);
    step();
    chk("t1_enable_off", enable_to_predictor, 0);

    // Direction mispredict; tag 1 is ready but must be ignored during the flush cycle.
    do_alloc(4'd1, 32'h500, 1'b0, 32'h540);
    do_resolve(4'd1, 1'b0, 32'h540);
    do_alloc(4'd5, 32'h200, 1'b0, 32'h240);
    do_resolve(4'd5, 1'b1, 32'h240);
    do_commit(4'd5);
    chk("t2_enable", enable_to_predictor, 1);
    chk("t2_result", jump_result_to_predictor, 1);
    chk("t2_flush", flush_out, 1);
    chk("t2_redirect", redirect_pc_out, 32'h240);
    commit_valid_in = 1'b1; commit_tag_in = 4'd1;
    alloc_valid_in = 1'b1; alloc_tag_in = 4'd6; alloc_pc_in = 32'h600;
    alloc_pred_taken_in = 1'b0; alloc_pred_target_in = 32'h640;
    #1;
    chk("t2_flush_ready", commit_ready_out, 0);
    step();
    commit_valid_in = 1'b0; alloc_valid_in = 1'b0;
    chk("t2_post_enable", enable_to_predictor, 0);
    chk("t2_post_flush", flush_out, 0);
    commit_tag_in = 4'd1; #1;
    chk("t2_tag1_cleared", commit_ready_out, 0);
    do_resolve(4'd6, 1'b0, 32'h640);
    commit_tag_in = 4'd6; #1;
    chk("t2_alloc_ignored", commit_ready_out, 0);

    // Target mispredict, then not-taken mispredict with pc+4 wrap.
    do_alloc(4'd2, 32'h280, 1'b1, 32'h300);
    do_resolve(4'd2, 1'b1, 32'h310);
    do_commit(4'd2);
    chk("t3_flush", flush_out, 1);
    chk("t3_redirect", redirect_pc_out, 32'h310);
    step();
    do_alloc(4'd4, 32'hFFFF_FFFC, 1'b1, 32'h10);
    do_resolve(4'd4, 1'b0, 32'h10);
    do_commit(4'd4);
    chk("t3_wrap_flush", flush_out, 1);
    chk("t3_wrap_redirect", redirect_pc_out, 32'h0);
    chk("t3_wrap_addr", inst_addr_to_predictor, 32'hFFFF_FFFC);
    chk("t3_wrap_result", jump_result_to_predictor, 0);
    step();

    // Commit before resolve, then resolve+commit same cycle, then commit.
    do_alloc(4'd7, 32'h700, 1'b0, 32'h780);
    commit_tag_in = 4'd7; #1;
    chk("t4_unresolved_ready", commit_ready_out, 0);
    do_commit(4'd7);
    chk("t4_unresolved_enable", enable_to_predictor, 0);
    commit_valid_in = 1'b1; commit_tag_in = 4'd7;
    resolve_valid_in = 1'b1; resolve_tag_in = 4'd7; resolve_taken_in = 1'b0;
    resolve_target_in = 32'h780;
    #1;
    chk("t4_same_cycle_ready", commit_ready_out, 0);
    step();
    resolve_valid_in = 1'b0;
    chk("t4_same_cycle_enable", enable_to_predictor, 0);
    #1;
    chk("t4_later_ready", commit_ready_out, 1);
    step();
    commit_valid_in = 1'b0;
    chk("t4_later_enable", enable_to_predictor, 1);
    chk("t4_later_addr", inst_addr_to_predictor, 32'h700);

    // Back-to-back commits with a rdy_in stall in between.
    do_alloc(4'd8, 32'h800, 1'b0, 32'h840);
    do_alloc(4'd9, 32'h900, 1'b0, 32'h940);
    do_alloc(4'd10, 32'hA00, 1'b0, 32'hA40);
    do_resolve(4'd8, 1'b0, 32'h840);
    do_resolve(4'd9, 1'b0, 32'h940);
    do_resolve(4'd10, 1'b0, 32'hA40);
    commit_valid_in = 1'b1; commit_tag_in = 4'd8;
    step();
    chk("t5_first_enable", enable_to_predictor, 1);
    chk("t5_first_addr", inst_addr_to_predictor, 32'h800);
    commit_tag_in = 4'd9;
    step();
    chk("t5_second_enable", enable_to_predictor, 1);
    chk("t5_second_addr", inst_addr_to_predictor, 32'h900);
    rdy_in = 1'b0; commit_tag_in = 4'd10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall_enable", enable_to_predictor, 1);
      chk("t5_stall_addr", inst_addr_to_predictor, 32'h900);
    end
    rdy_in = 1'b1;
    step();
    commit_valid_in = 1'b0;
    chk("t5_resume_enable", enable_to_predictor, 1);
    chk("t5_resume_addr", inst_addr_to_predictor, 32'hA00);
    step();
    chk("t5_idle_enable", enable_to_predictor, 0);

`ifdef BRANCH_STAT_EN
    rst_in = 1'b1; step(); rst_in = 1'b0;
    chk("st_rst_br", stat_branches_out, 0);
    chk("st_rst_mp", stat_mispredicts_out, 0);
    for (int i = 0; i < 3; i++) begin
      do_alloc(4'(i), 32'h1000 + 32'(i * 16), 1'b0, 32'h2000);
      do_resolve(4'(i), 1'b0, 32'h2000);
      do_commit(4'(i));
    end
    do_alloc(4'd11, 32'h3000, 1'b0, 32'h3040);
    do_resolve(4'd11, 1'b1, 32'h3040);
    do_commit(4'd11);
    step();
    chk("st_br", stat_branches_out, 4);
    chk("st_mp", stat_mispredicts_out, 1);
    rst_in = 1'b1; step(); rst_in = 1'b0;
    chk("st_rst2_br", stat_branches_out, 0);
    chk("st_rst2_mp", stat_mispredicts_out, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
